// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline tail.
//   wb_state_e : writeback FSM encoding (IDLE / WAIT_MEM / DONE)
//   AL_*       : bit positions inside the one-hot align_load vector
//   SRC_*      : bit positions inside the one-hot rf_wdata_src vector
//   EXC_NONE   : exception code meaning "no exception"
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DONE     = 2'd2
  } wb_state_e;

  localparam int unsigned AL_LW  = 6;
  localparam int unsigned AL_LB  = 5;
  localparam int unsigned AL_LBU = 4;
  localparam int unsigned AL_LH  = 3;
  localparam int unsigned AL_LHU = 2;
  localparam int unsigned AL_LWL = 1;
  localparam int unsigned AL_LWR = 0;

  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_LOAD = 1;
  localparam int unsigned SRC_RSVD = 2;

  localparam logic [4:0] EXC_NONE = 5'd0;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load-data alignment / extension.
// Ports:
//   align_load [6:0] one-hot load kind (lw lb lbu lh lhu lwl lwr)
//   addr       [1:0] low byte-address bits of the load
//   rdata      [31:0] word returned by memory
//   rf_B       [31:0] old rt value, merged by lwl/lwr
//   result     [31:0] value to write into the register file
// No kind bit set falls through to the plain word.
module load_align
  import pipe_pkg::*;
(
  input  logic [6:0]  align_load,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] rf_B,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    if (align_load[AL_LB]) begin
      result = {{24{byte_sel[7]}}, byte_sel};
    end else if (align_load[AL_LBU]) begin
      result = {24'd0, byte_sel};
    end else if (align_load[AL_LH]) begin
      result = {{16{half_sel[15]}}, half_sel};
    end else if (align_load[AL_LHU]) begin
      result = {16'd0, half_sel};
    end else if (align_load[AL_LWL]) begin
      case (addr)
        2'd0: result = {rdata[7:0],  rf_B[23:0]};
        2'd1: result = {rdata[15:0], rf_B[15:0]};
        2'd2: result = {rdata[23:0], rf_B[7:0]};
        default: result = rdata;
      endcase
    end else if (align_load[AL_LWR]) begin
      case (addr)
        2'd0: result = rdata;
        2'd1: result = {rf_B[31:24], rdata[31:8]};
        2'd2: result = {rf_B[31:16], rdata[31:16]};
        default: result = {rf_B[31:8], rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage. Latches the retiring instruction, waits
// for load data, aligns it and drives the single register-file write port.
// Ports:
//   clk, rst_p (async, active-high)   empty : flush, kills held instruction
//   MA_ready / WB_enable             : upstream handshake
//   *_in, MA_PC                      : instruction fields from MA stage
//   mem_rdata / mem_data_ok          : load data return (1-cycle pulse)
//   rf_wen / rf_waddr / rf_wdata     : register-file write port
//   valid_out / leaving_out          : forwarding status
//   WB_PC                            : PC of held instruction
// Optional (macro WB_DEBUG_TRACE_EN): debug_wb_pc, debug_wb_rf_wen,
//   debug_wb_rf_wnum, debug_wb_rf_wdata trace outputs.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned RDATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_p,
  input  logic               empty,
  input  logic               MA_ready,
  output logic               WB_enable,
  input  logic [31:0]        rf_B_in,
  input  logic [4:0]         rf_waddr_in,
  input  logic [2:0]         rf_wdata_src_in,
  input  logic               rf_wen_in,
  input  logic [31:0]        alu_res_in,
  input  logic               mem_read_in,
  input  logic [6:0]         align_load_in,
  input  logic [4:0]         exccode_in,
  input  logic [31:0]        MA_PC,
  input  logic [RDATA_W-1:0] mem_rdata,
  input  logic               mem_data_ok,
  output logic               rf_wen,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               valid_out,
  output logic               leaving_out,
  output logic [31:0]        WB_PC
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]        debug_wb_pc,
  output logic [3:0]         debug_wb_rf_wen,
  output logic [4:0]         debug_wb_rf_wnum,
  output logic [31:0]        debug_wb_rf_wdata
`endif
);

  if (RDATA_W != 32) begin : g_bad_width
    $error("wb_stage: RDATA_W must be 32");
  end

  wb_state_e   state;
  logic [31:0] rf_B_q;
  logic [4:0]  waddr_q;
  logic        src_load_q;
  logic        wen_q;
  logic [31:0] alu_res_q;
  logic [6:0]  align_q;
  logic [4:0]  exc_q;
  logic [31:0] rdata_q;
  logic        drop_pending;
  logic [31:0] load_data;

  logic comming;
  logic load_entry;
  logic data_take;
  logic drop_next;
  logic unused_src_bits;

  assign unused_src_bits = rf_wdata_src_in[SRC_ALU] ^ rf_wdata_src_in[SRC_RSVD];

  // Outputs derive from registered state only, so leaving_out never
  // sees MA_ready combinationally.
  assign valid_out   = (state != ST_IDLE);
  assign leaving_out = (state == ST_DONE);
  assign WB_enable   = !valid_out || leaving_out;
  assign comming     = WB_enable && MA_ready;
  assign load_entry  = mem_read_in && (exccode_in == EXC_NONE);
  assign data_take   = (state == ST_WAIT_MEM) && mem_data_ok && !drop_pending;

  // A pulse consumes one pending drop; a flush in WAIT_MEM leaves one
  // outstanding response unless its data is arriving in that same cycle.
  assign drop_next = (drop_pending && !mem_data_ok) ||
                     (empty && (state == ST_WAIT_MEM) && !data_take);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state        <= ST_IDLE;
      rf_B_q       <= '0;
      waddr_q      <= '0;
      src_load_q   <= 1'b0;
      wen_q        <= 1'b0;
      alu_res_q    <= '0;
      align_q      <= '0;
      exc_q        <= '0;
      WB_PC        <= '0;
      rdata_q      <= '0;
      drop_pending <= 1'b0;
    end else begin
      drop_pending <= drop_next;
      if (comming) begin
        rf_B_q     <= rf_B_in;
        waddr_q    <= rf_waddr_in;
        src_load_q <= rf_wdata_src_in[SRC_LOAD];
        wen_q      <= rf_wen_in;
        alu_res_q  <= alu_res_in;
        align_q    <= align_load_in;
        exc_q      <= exccode_in;
        WB_PC      <= MA_PC;
      end
      if (data_take) begin
        rdata_q <= mem_rdata;
      end
      if (empty) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_WAIT_MEM: if (data_take) state <= ST_DONE;
          default: begin
            if (comming) state <= load_entry ? ST_WAIT_MEM : ST_DONE;
            else         state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  load_align u_load_align (
    .align_load (align_q),
    .addr       (alu_res_q[1:0]),
    .rdata      (rdata_q),
    .rf_B       (rf_B_q),
    .result     (load_data)
  );

  assign rf_wen   = (state == ST_DONE) && wen_q && (exc_q == EXC_NONE) && !empty;
  assign rf_waddr = waddr_q;
  assign rf_wdata = src_load_q ? load_data : alu_res_q;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = WB_PC;
  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

  // Memory returns data no earlier than the cycle after the request.
  a_no_data_on_entry: assert property (@(posedge clk) disable iff (rst_p)
    !(comming && !empty && load_entry && mem_data_ok && !drop_pending));

  // A response is only legal while a load waits or a killed load is owed one.
  a_data_ok_protocol: assert property (@(posedge clk) disable iff (rst_p)
    mem_data_ok |-> ((state == ST_WAIT_MEM) || drop_pending));

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_p;
  logic        empty;
  logic        MA_ready;
  logic        WB_enable;
  logic [31:0] rf_B_in;
  logic [4:0]  rf_waddr_in;
  logic [2:0]  rf_wdata_src_in;
  logic        rf_wen_in;
  logic [31:0] alu_res_in;
  logic        mem_read_in;
  logic [6:0]  align_load_in;
  logic [4:0]  exccode_in;
  logic [31:0] MA_PC;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        valid_out;
  logic        leaving_out;
  logic [31:0] WB_PC;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage #(.RDATA_W(32)) dut (
    .clk             (clk),
    .rst_p           (rst_p),
    .empty           (empty),
    .MA_ready        (MA_ready),
    .WB_enable       (WB_enable),
    .rf_B_in         (rf_B_in),
    .rf_waddr_in     (rf_waddr_in),
    .rf_wdata_src_in (rf_wdata_src_in),
    .rf_wen_in       (rf_wen_in),
    .alu_res_in      (alu_res_in),
    .mem_read_in     (mem_read_in),
    .align_load_in   (align_load_in),
    .exccode_in      (exccode_in),
    .MA_PC           (MA_PC),
    .mem_rdata       (mem_rdata),
    .mem_data_ok     (mem_data_ok),
    .rf_wen          (rf_wen),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .valid_out       (valid_out),
    .leaving_out     (leaving_out),
    .WB_PC           (WB_PC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction, hold it through one accepting edge, then withdraw.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] wa,
                       input logic [2:0] src, input logic ld, input logic [6:0] al,
                       input logic [4:0] exc, input logic [31:0] b);
    MA_PC = pc; alu_res_in = alu; rf_waddr_in = wa; rf_wdata_src_in = src;
    mem_read_in = ld; align_load_in = al; exccode_in = exc; rf_B_in = b;
    rf_wen_in = 1'b1; MA_ready = 1'b1;
    @(posedge clk); #1;
    MA_ready = 1'b0;
  endtask

  task automatic pulse_data(input logic [31:0] d);
    mem_rdata = d; mem_data_ok = 1'b1;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_p = 1'b1; empty = 1'b0; MA_ready = 1'b0; rf_B_in = '0; rf_waddr_in = '0;
    rf_wdata_src_in = '0; rf_wen_in = 1'b0; alu_res_in = '0; mem_read_in = 1'b0;
    align_load_in = '0; exccode_in = '0; MA_PC = '0; mem_rdata = '0; mem_data_ok = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",   32'(valid_out),   32'd0);
    chk("rst_leaving", 32'(leaving_out), 32'd0);
    chk("rst_rfwen",   32'(rf_wen),      32'd0);
    chk("rst_enable",  32'(WB_enable),   32'd1);
    chk("rst_pc",      WB_PC,            32'd0);
    chk("rst_wdata",   rf_wdata,         32'd0);
    rst_p = 1'b0;
    @(posedge clk); #1;

    // addu: retires one cycle after entry
    chk("addu_enable_pre", 32'(WB_enable), 32'd1);
    issue(32'h100, 32'h0000_1234, 5'd5, 3'b001, 1'b0, 7'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("addu_leaving", 32'(leaving_out), 32'd1);
    chk("addu_rfwen",   32'(rf_wen),      32'd1);
    chk("addu_wdata",   rf_wdata,         32'h0000_1234);
    chk("addu_waddr",   32'(rf_waddr),    32'd5);
    chk("addu_pc",      WB_PC,            32'h100);
    chk("addu_enable",  32'(WB_enable),   32'd1);
    @(posedge clk); #1;
    chk("addu_idle", 32'(valid_out), 32'd0);

    // lb at ...01, data three cycles later
    issue(32'h104, 32'h0000_1001, 5'd7, 3'b010, 1'b1, 7'b0100000, 5'd0, 32'h0);
    @(negedge clk);
    chk("lb_wait_valid",   32'(valid_out),   32'd1);
    chk("lb_wait_leaving", 32'(leaving_out), 32'd0);
    chk("lb_wait_enable",  32'(WB_enable),   32'd0);
    chk("lb_wait_rfwen",   32'(rf_wen),      32'd0);
    repeat (2) @(posedge clk);
    #1;
    pulse_data(32'h1122_8344);
    @(negedge clk);
    chk("lb_leaving", 32'(leaving_out), 32'd1);
    chk("lb_rfwen",   32'(rf_wen),      32'd1);
    chk("lb_wdata",   rf_wdata,         32'hFFFF_FF83);
    @(posedge clk); #1;

    // lbu, same address and data
    issue(32'h108, 32'h0000_1001, 5'd7, 3'b010, 1'b1, 7'b0010000, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    pulse_data(32'h1122_8344);
    @(negedge clk);
    chk("lbu_wdata", rf_wdata, 32'h0000_0083);
    @(posedge clk); #1;

    // lwl at ...01
    issue(32'h10C, 32'h0000_2001, 5'd8, 3'b010, 1'b1, 7'b0000010, 5'd0, 32'hAABB_CCDD);
    pulse_data(32'h1122_3344);
    @(negedge clk);
    chk("lwl_wdata", rf_wdata, 32'h3344_CCDD);
    @(posedge clk); #1;

    // lwr at ...02
    issue(32'h110, 32'h0000_2002, 5'd8, 3'b010, 1'b1, 7'b0000001, 5'd0, 32'hAABB_CCDD);
    pulse_data(32'h1122_3344);
    @(negedge clk);
    chk("lwr_wdata", rf_wdata, 32'hAABB_1122);
    @(posedge clk); #1;

    // lh at ...02: upper half, sign-extended
    issue(32'h114, 32'h0000_3002, 5'd9, 3'b010, 1'b1, 7'b0001000, 5'd0, 32'h0);
    pulse_data(32'h9876_1234);
    @(negedge clk);
    chk("lh_wdata", rf_wdata, 32'hFFFF_9876);
    @(posedge clk); #1;

    // excepting load: no memory wait, no write
    issue(32'h118, 32'h0000_4000, 5'd10, 3'b010, 1'b1, 7'b1000000, 5'd4, 32'h0);
    @(negedge clk);
    chk("exc_leaving", 32'(leaving_out), 32'd1);
    chk("exc_rfwen",   32'(rf_wen),      32'd0);
    @(posedge clk); #1;
    chk("exc_idle", 32'(valid_out), 32'd0);

    // back-to-back non-loads: DONE -> DONE
    issue(32'h120, 32'h0000_0011, 5'd1, 3'b001, 1'b0, 7'b0, 5'd0, 32'h0);
    issue(32'h124, 32'h0000_0022, 5'd2, 3'b100, 1'b0, 7'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("b2b_pc",    WB_PC,           32'h124);
    chk("b2b_wdata", rf_wdata,        32'h0000_0022);
    chk("b2b_rfwen", 32'(rf_wen),     32'd1);
    @(posedge clk); #1;

    // flush during WAIT_MEM; stale response lands while a new lw waits
    issue(32'h130, 32'h0000_5000, 5'd11, 3'b010, 1'b1, 7'b1000000, 5'd0, 32'h0);
    empty = 1'b1;
    @(negedge clk);
    chk("flush_rfwen", 32'(rf_wen), 32'd0);
    @(posedge clk); #1;
    empty = 1'b0;
    chk("flush_idle", 32'(valid_out), 32'd0);
    issue(32'h134, 32'h0000_6000, 5'd12, 3'b010, 1'b1, 7'b1000000, 5'd0, 32'h0);
    pulse_data(32'h1234_5678);
    @(negedge clk);
    chk("stale_valid",   32'(valid_out),   32'd1);
    chk("stale_leaving", 32'(leaving_out), 32'd0);
    @(posedge clk); #1;
    pulse_data(32'hDEAD_BEEF);
    @(negedge clk);
    chk("newlw_rfwen", 32'(rf_wen),    32'd1);
    chk("newlw_wdata", rf_wdata,       32'hDEAD_BEEF);
    chk("newlw_waddr", 32'(rf_waddr),  32'd12);
    chk("newlw_pc",    WB_PC,          32'h134);
    @(posedge clk); #1;

    // asynchronous reset while waiting on memory
    issue(32'h140, 32'h0000_7000, 5'd13, 3'b010, 1'b1, 7'b1000000, 5'd0, 32'h0);
    @(negedge clk);
    chk("arst_pre_valid", 32'(valid_out), 32'd1);
    #2 rst_p = 1'b1;
    #1;
    chk("arst_valid",  32'(valid_out), 32'd0);
    chk("arst_rfwen",  32'(rf_wen),    32'd0);
    chk("arst_pc",     WB_PC,          32'd0);
    chk("arst_enable", 32'(WB_enable), 32'd1);
    @(posedge clk); #1;
    rst_p = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
